// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the fetch/decode front end
package rv32i_types;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;
endpackage

// File: rtl/iq_ram.sv
// iq_ram: entry storage, one sync write port and one async read port, no reset
module iq_ram
  import rv32i_types::*;
#(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  iq_entry_t         wdata,
  input  logic [ADDR_W-1:0] raddr,
  output iq_entry_t         rdata
);
  iq_entry_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_queue.sv
// instr_queue: circular fetch-to-decode FIFO with dispatch backpressure and flush.
// Define IQ_PERF_EN to add saturating issue/stall performance counters.
module instr_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              enq_valid,
  input  logic [31:0]       enq_pc,
  input  logic [31:0]       enq_inst,
  output logic              full,
  input  logic              dis_freeze,
  output logic              iq_re,
  output logic [31:0]       deq_pc,
  output logic [31:0]       deq_inst,
  output logic              empty,
`ifdef IQ_PERF_EN
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic [ADDR_W:0]   count
);
  logic [ADDR_W:0] wptr, rptr;
  logic we;
  iq_entry_t head;
  assign count = wptr - rptr;
  assign empty = wptr == rptr;
  assign full = count == (ADDR_W+1)'(DEPTH);
  assign iq_re = !empty && !dis_freeze && !flush;
  assign we = enq_valid && !full && !flush;
  assign deq_pc = head.pc;
  assign deq_inst = head.inst;
  iq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(wptr[ADDR_W-1:0]),
    .wdata('{pc: enq_pc, inst: enq_inst}),
    .raddr(rptr[ADDR_W-1:0]),
    .rdata(head)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + (ADDR_W+1)'(we);
      rptr <= rptr + (ADDR_W+1)'(iq_re);
    end
  end
`ifdef IQ_PERF_EN
  // Counters survive flush; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (iq_re && perf_issue_cnt != '1) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (!empty && dis_freeze && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
